mmio_initiator: RTL and testbench

MMIO_INITIATOR -- requirements
Module: mmio_initiator

---
 rtl/mmio_initiator_if.sv | 47 ++++
 rtl/mmio_initiator.sv | 166 ++++++++++++++++
 tb/tb_mmio_initiator.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_initiator_if
// Description : Command/response handshake plus simple peripheral bus bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [31:0] cmd_mask;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;

    // Initiator side
    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output sel, we, addr, wdata, busy,
        input  rdata
    );

    // Command source / response sink / peripheral side
    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  sel, we, addr, wdata, busy,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/mmio_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mmio_initiator
// Description : Executes write/read/poll commands as single-cycle MMIO accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_initiator #(
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 4
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    mmio_initiator_if.master  mmio
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_GAP    = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0]  c_OP_WRITE = 2'b00;
    localparam logic [1:0]  c_OP_READ  = 2'b01;
    localparam logic [1:0]  c_OP_POLL  = 2'b10;
    localparam logic [1:0]  c_OP_RSVD  = 2'b11;
    localparam logic [15:0] c_POLL_MAX = 16'(POLL_MAX);
    localparam logic [7:0]  c_GAP_LAST = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;
    localparam bit          c_NO_GAP   = (POLL_GAP == 0);

    state_t      r_state;
    logic [1:0]  r_op;
    logic [31:0] r_mask;
    logic [15:0] r_cnt;
    logic [7:0]  r_gap;
    logic        r_cmd_ready;
    logic        r_sel;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_busy;

    logic        w_accept;
    logic [15:0] w_cnt_next;
    logic        w_match;
    logic        w_expired;

    assign w_accept   = mmio.cmd_valid & r_cmd_ready;
    // Saturate so the count can never wrap back below POLL_MAX
    assign w_cnt_next = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_match    = ((mmio.rdata ^ r_wdata) & r_mask) == 32'd0;
    assign w_expired  = (w_cnt_next >= c_POLL_MAX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_op        <= c_OP_WRITE;
            r_mask      <= 32'd0;
            r_cnt       <= 16'd0;
            r_gap       <= 8'd0;
            r_cmd_ready <= 1'b1;
            r_sel       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op        <= mmio.cmd_op;
                        r_mask      <= mmio.cmd_mask;
                        r_cnt       <= 16'd0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (mmio.cmd_op == c_OP_RSVD) begin
                            // No bus access, so the bus outputs keep their old values
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= 32'd0;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state <= S_ACCESS;
                            r_sel   <= 1'b1;
                            r_we    <= (mmio.cmd_op == c_OP_WRITE);
                            r_addr  <= mmio.cmd_addr;
                            r_wdata <= mmio.cmd_wdata;
                        end
                    end
                end

                S_ACCESS: begin
                    if (r_op == c_OP_POLL) begin
                        r_cnt       <= w_cnt_next;
                        r_rsp_rdata <= mmio.rdata;
                        if (w_match || w_expired) begin
                            r_state     <= S_RESP;
                            r_sel       <= 1'b0;
                            r_we        <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= ~w_match;
                        end else if (c_NO_GAP) begin
                            r_state <= S_ACCESS;
                        end else begin
                            r_state <= S_GAP;
                            r_sel   <= 1'b0;
                            r_gap   <= 8'd0;
                        end
                    end else begin
                        r_state     <= S_RESP;
                        r_sel       <= 1'b0;
                        r_we        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= (r_op == c_OP_READ) ? mmio.rdata : 32'd0;
                        r_rsp_err   <= 1'b0;
                    end
                end

                S_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= S_ACCESS;
                        r_sel   <= 1'b1;
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end

                S_RESP: begin
                    if (mmio.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_sel       <= 1'b0;
                    r_we        <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign mmio.cmd_ready = r_cmd_ready;
    assign mmio.rsp_valid = r_rsp_valid;
    assign mmio.rsp_rdata = r_rsp_rdata;
    assign mmio.rsp_err   = r_rsp_err;
    assign mmio.sel       = r_sel;
    assign mmio.we        = r_we;
    assign mmio.addr      = r_addr;
    assign mmio.wdata     = r_wdata;
    assign mmio.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mmio_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_initiator
// Description : Directed scoreboard bench with a small timer peripheral model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_initiator;

    localparam int MAX_A = 16;
    localparam int GAP_A = 3;
    localparam int MAX_B = 4;
    localparam int GAP_B = 0;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mmio_initiator_if bus_a ();
    mmio_initiator_if bus_b ();

    mmio_initiator #(.POLL_MAX(MAX_A), .POLL_GAP(GAP_A)) u_dut_a (
        .clk    (clk),
        .resetn (resetn),
        .mmio   (bus_a)
    );

    mmio_initiator #(.POLL_MAX(MAX_B), .POLL_GAP(GAP_B)) u_dut_b (
        .clk    (clk),
        .resetn (resetn),
        .mmio   (bus_b)
    );

    assign bus_b.rdata = 32'd0;

    // Timer: 0x00 ctrl (bit0 enable), 0x04 load, 0x08 count, 0x0C sticky timeout flag
    logic [31:0] t_ctrl, t_load, t_cnt;
    logic [1:0]  t_pre;
    logic        t_flag;

    always_comb begin
        case (bus_a.addr)
            32'h00:  bus_a.rdata = t_ctrl;
            32'h04:  bus_a.rdata = t_load;
            32'h08:  bus_a.rdata = t_cnt;
            32'h0C:  bus_a.rdata = {31'd0, t_flag};
            default: bus_a.rdata = 32'd0;
        endcase
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            t_ctrl <= 32'd0; t_load <= 32'd0; t_cnt <= 32'd0; t_pre <= 2'd0; t_flag <= 1'b0;
        end else begin
            if (bus_a.sel && !bus_a.we && bus_a.addr == 32'h0C) t_flag <= 1'b0;
            if (t_ctrl[0]) begin
                t_pre <= t_pre + 2'd1;
                if (t_pre == 2'd3) begin
                    if (t_cnt == 32'd0) begin
                        t_flag <= 1'b1;
                        t_cnt  <= t_load;
                    end else begin
                        t_cnt <= t_cnt - 32'd1;
                    end
                end
            end
            if (bus_a.sel && bus_a.we && bus_a.addr == 32'h00) t_ctrl <= bus_a.wdata;
            if (bus_a.sel && bus_a.we && bus_a.addr == 32'h04) begin
                t_load <= bus_a.wdata;
                t_cnt  <= bus_a.wdata;
            end
        end
    end

    int cyc   = 0;
    int sel_a = 0;
    int sel_b = 0;
    int sel_a_cyc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus_a.sel) begin
            sel_a <= sel_a + 1;
            sel_a_cyc.push_back(cyc);
        end
        if (bus_b.sel) sel_b <= sel_b + 1;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic e);
        rsp_t r;
        r.rdata = d;
        r.err   = e;
        sb.push_back(r);
    endtask

    task automatic send_a(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] m, output int s0);
        int n = 0;
        @(negedge clk);
        while (!bus_a.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_send", bus_a.cmd_ready, 1);
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_op    = op;
        bus_a.cmd_addr  = a;
        bus_a.cmd_wdata = d;
        bus_a.cmd_mask  = m;
        @(posedge clk);
        #1 bus_a.cmd_valid = 1'b0;
        s0 = sel_a;
    endtask

    task automatic recv_a(input int hold);
        int          n = 0;
        logic [31:0] d0;
        logic        e0;
        rsp_t        e;
        while (!bus_a.rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_arrives", bus_a.rsp_valid, 1);
        check("cmd_ready_low_in_resp", bus_a.cmd_ready, 0);
        d0 = bus_a.rsp_rdata;
        e0 = bus_a.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", bus_a.rsp_valid, 1);
            check("hold_rsp_rdata", bus_a.rsp_rdata, d0);
            check("hold_rsp_err", bus_a.rsp_err, e0);
            check("hold_cmd_ready", bus_a.cmd_ready, 0);
            check("hold_sel", bus_a.sel, 0);
        end
        e.rdata = 32'd0;
        e.err   = 1'b0;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL sb_underflow: observed response with rdata %h, expected none", bus_a.rsp_rdata);
        end else begin
            e = sb.pop_front();
            check("rsp_rdata", bus_a.rsp_rdata, e.rdata);
            check("rsp_err", bus_a.rsp_err, e.err);
        end
        bus_a.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus_a.rsp_ready = 1'b0;
        @(negedge clk);
        check("post_rsp_valid", bus_a.rsp_valid, 0);
        check("post_rsp_rdata_held", bus_a.rsp_rdata, e.rdata);
        check("post_rsp_err_held", bus_a.rsp_err, e.err);
        check("post_cmd_ready", bus_a.cmd_ready, 1);
        check("post_busy", bus_a.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   s0;
        int   n;
        int   seen;
        rsp_t e;

        bus_a.cmd_valid = 1'b0; bus_a.cmd_op = 2'b00; bus_a.cmd_addr = 32'd0;
        bus_a.cmd_wdata = 32'd0; bus_a.cmd_mask = 32'd0; bus_a.rsp_ready = 1'b0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_op = 2'b00; bus_b.cmd_addr = 32'd0;
        bus_b.cmd_wdata = 32'd0; bus_b.cmd_mask = 32'd0; bus_b.rsp_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus_a.cmd_ready, 1);
        check("rst_sel", bus_a.sel, 0);
        check("rst_we", bus_a.we, 0);
        check("rst_addr", bus_a.addr, 0);
        check("rst_wdata", bus_a.wdata, 0);
        check("rst_rsp_valid", bus_a.rsp_valid, 0);
        check("rst_rsp_rdata", bus_a.rsp_rdata, 0);
        check("rst_rsp_err", bus_a.rsp_err, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_b_cmd_ready", bus_b.cmd_ready, 1);
        resetn = 1'b1;

        // Write 5 to timer load
        expect_rsp(32'd0, 1'b0);
        send_a(2'b00, 32'h04, 32'd5, 32'd0, s0);
        @(negedge clk);
        check("wr_sel", bus_a.sel, 1);
        check("wr_we", bus_a.we, 1);
        check("wr_addr", bus_a.addr, 32'h04);
        check("wr_wdata", bus_a.wdata, 32'd5);
        check("wr_busy", bus_a.busy, 1);
        check("wr_cmd_ready", bus_a.cmd_ready, 0);
        check("wr_rsp_early", bus_a.rsp_valid, 0);
        @(negedge clk);
        check("wr_sel_drop", bus_a.sel, 0);
        check("wr_we_drop", bus_a.we, 0);
        check("wr_addr_hold", bus_a.addr, 32'h04);
        check("wr_rsp_latency", bus_a.rsp_valid, 1);
        recv_a(0);
        #1;
        check("wr_sel_pulses", sel_a - s0, 1);
        check("timer_load", t_load, 32'd5);

        // Read it back
        expect_rsp(32'd5, 1'b0);
        send_a(2'b01, 32'h04, 32'd0, 32'd0, s0);
        @(negedge clk);
        check("rd_sel", bus_a.sel, 1);
        check("rd_we", bus_a.we, 0);
        check("rd_addr", bus_a.addr, 32'h04);
        @(negedge clk);
        check("rd_rsp_latency", bus_a.rsp_valid, 1);
        recv_a(0);
        #1;
        check("rd_sel_pulses", sel_a - s0, 1);

        // Load 3, then read with a stalled response
        expect_rsp(32'd0, 1'b0);
        send_a(2'b00, 32'h04, 32'd3, 32'd0, s0);
        recv_a(0);
        expect_rsp(32'd3, 1'b0);
        send_a(2'b01, 32'h04, 32'd0, 32'd0, s0);
        recv_a(10);

        // Reserved op: no access, error response, stalled
        expect_rsp(32'd0, 1'b1);
        send_a(2'b11, 32'h40, 32'hDEAD_BEEF, 32'd0, s0);
        @(negedge clk);
        check("rsvd_sel", bus_a.sel, 0);
        check("rsvd_addr_hold", bus_a.addr, 32'h04);
        check("rsvd_wdata_hold", bus_a.wdata, 32'd0);
        check("rsvd_rsp", bus_a.rsp_valid, 1);
        check("rsvd_busy", bus_a.busy, 1);
        recv_a(10);
        #1;
        check("rsvd_sel_pulses", sel_a - s0, 0);

        // Enable timer, poll status until timeout flag
        expect_rsp(32'd0, 1'b0);
        send_a(2'b00, 32'h00, 32'd1, 32'd0, s0);
        recv_a(0);
        expect_rsp(32'd1, 1'b0);
        send_a(2'b10, 32'h0C, 32'd1, 32'd1, s0);
        recv_a(0);
        #1;
        n = sel_a - s0;
        check("poll_multi_read", (n >= 2), 1);
        check("poll_within_max", (n <= MAX_A), 1);
        for (int i = 1; i < n; i++)
            check("poll_read_period", sel_a_cyc[s0+i] - sel_a_cyc[s0+i-1], GAP_A + 1);

        // Poll a constant-zero location until expiry
        expect_rsp(32'd0, 1'b1);
        send_a(2'b10, 32'h10, 32'd1, 32'd1, s0);
        recv_a(0);
        #1;
        n = sel_a - s0;
        check("expire_sel_pulses", n, MAX_A);
        check("expire_first_period", sel_a_cyc[s0+1] - sel_a_cyc[s0], GAP_A + 1);
        check("expire_last_period", sel_a_cyc[s0+MAX_A-1] - sel_a_cyc[s0+MAX_A-2], GAP_A + 1);

        // Zero-gap instance: back-to-back reads, expiry after MAX_B
        expect_rsp(32'd0, 1'b1);
        @(negedge clk);
        check("b_cmd_ready", bus_b.cmd_ready, 1);
        bus_b.cmd_valid = 1'b1; bus_b.cmd_op = 2'b10; bus_b.cmd_addr = 32'h20;
        bus_b.cmd_wdata = 32'd1; bus_b.cmd_mask = 32'd1;
        @(posedge clk);
        #1 bus_b.cmd_valid = 1'b0;
        s0 = sel_b;
        n  = 0;
        while (!bus_b.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b_rsp_valid", bus_b.rsp_valid, 1);
        check("b_back_to_back_latency", n, MAX_B + 1);
        e = sb.pop_front();
        check("b_rsp_rdata", bus_b.rsp_rdata, e.rdata);
        check("b_rsp_err", bus_b.rsp_err, e.err);
        #1;
        check("b_sel_pulses", sel_b - s0, MAX_B);
        bus_b.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus_b.rsp_ready = 1'b0;

        // Reset while sel is high drops it immediately
        @(negedge clk);
        bus_b.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus_b.cmd_valid = 1'b0;
        @(negedge clk);
        check("b_sel_before_reset", bus_b.sel, 1);
        #2 resetn = 1'b0;
        #1;
        check("b_async_sel", bus_b.sel, 0);
        check("b_async_busy", bus_b.busy, 0);
        check("b_async_cmd_ready", bus_b.cmd_ready, 1);
        @(negedge clk);
        resetn = 1'b1;

        // Reset during GAP aborts the poll
        send_a(2'b10, 32'h10, 32'd1, 32'd1, s0);
        @(negedge clk);
        check("gap_sel_first", bus_a.sel, 1);
        @(negedge clk);
        check("gap_sel_idle", bus_a.sel, 0);
        check("gap_busy", bus_a.busy, 1);
        #2 resetn = 1'b0;
        #1;
        check("gaprst_cmd_ready", bus_a.cmd_ready, 1);
        check("gaprst_sel", bus_a.sel, 0);
        check("gaprst_we", bus_a.we, 0);
        check("gaprst_addr", bus_a.addr, 0);
        check("gaprst_wdata", bus_a.wdata, 0);
        check("gaprst_rsp_valid", bus_a.rsp_valid, 0);
        check("gaprst_rsp_rdata", bus_a.rsp_rdata, 0);
        check("gaprst_rsp_err", bus_a.rsp_err, 0);
        check("gaprst_busy", bus_a.busy, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_a.rsp_valid || bus_a.sel || bus_b.rsp_valid || bus_b.sel) seen++;
        end
        check("no_activity_after_reset", seen, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
